// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned INST_W       = 32;
  localparam int unsigned PC_W_DEF     = 32;
  localparam int unsigned RESET_PC_DEF = 0;

  localparam logic [5:0] OPC_J = 6'b000010;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  function automatic logic is_j(input logic [INST_W-1:0] inst);
    return inst[31:26] == OPC_J;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Valid/ready delivery channel from fetch to decode carrying {inst, pc}.
interface fetch_if #(
  parameter int unsigned PC_W = 32
);
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [PC_W-1:0] out_pc;

  modport master (output out_valid, output out_inst, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_inst, input out_pc, output out_ready);
endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO with push/pop/flush; sized for a consumer of a 1-cycle-latency source.
module fetch_queue #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok_c;

  assign pop_ok_c = pop && (count_q != 2'd0);

  // Flush discards contents and wins over any same-cycle push or pop.
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok_c) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(push) - 2'(pop_ok_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: drives imem_pc, absorbs 1-cycle memory latency, handles redirects and J.
// Optional bounds check (HALT + sticky fault) compiled in with FETCH_BOUNDS_CHECK_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF),
  parameter int unsigned     MEM_DEPTH = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_pc,
  input  logic [31:0]     imem_inst,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  fetch_if.master         dec,
  output logic            fault
);

  localparam int unsigned ENTRY_W = INST_W + PC_W;

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;

  logic [1:0]         q_count;
  logic [ENTRY_W-1:0] q_head;
  logic               out_valid_c;
  logic               deq_c;
  logic               room_c;
  logic               want_c;
  logic               oob_c;
  logic               issue_c;
  logic               push_c;
  logic               j_hit_c;
  logic [2:0]         occ_c;

  assign out_valid_c = (q_count != 2'd0);
  assign deq_c       = out_valid_c && dec.out_ready;
  assign occ_c       = 3'(q_count) + 3'(inflight_q) - 3'(deq_c);
  assign room_c      = occ_c < 3'd2;
  assign want_c      = (state_q == RUN) && room_c && !redirect_valid;

`ifdef FETCH_BOUNDS_CHECK_EN
  logic fault_q, fault_d;
  assign oob_c = fetch_pc_q >= PC_W'(MEM_DEPTH);
`else
  assign oob_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // A blocked out-of-range issue parks the FSM in HALT until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (want_c && oob_c) state_d = HALT;
      default: state_d = state_q;
    endcase
  end

  // Redirect beats J predecode, which beats the sequential increment.
  always_comb begin
    issue_c       = want_c && !oob_c;
    push_c        = inflight_q && !redirect_valid;
    j_hit_c       = push_c && is_j(imem_inst);
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = fetch_pc_q;
    if (redirect_valid)  fetch_pc_d = redirect_pc;
    else if (j_hit_c)    fetch_pc_d = PC_W'(imem_inst[25:0]);
    else if (issue_c)    fetch_pc_d = fetch_pc_q + PC_W'(1);
    // The sequential fetch issued alongside a captured J is dropped on arrival.
    inflight_d    = issue_c && !j_hit_c;
`ifdef FETCH_BOUNDS_CHECK_EN
    fault_d       = fault_q || (want_c && oob_c);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

`ifdef FETCH_BOUNDS_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  fetch_queue #(.W(ENTRY_W)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data ({imem_inst, inflight_pc_q}),
    .pop       (deq_c),
    .flush     (redirect_valid),
    .head_data (q_head),
    .count     (q_count)
  );

  assign imem_pc       = fetch_pc_q;
  assign dec.out_valid = out_valid_c;
  assign dec.out_inst  = q_head[ENTRY_W-1:PC_W];
  assign dec.out_pc    = q_head[PC_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot latency, stall, redirects, J predecode, optional bounds halt.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] mem [64];

  int n_cmp;
  int n_fail;

  fetch_if #(.PC_W(32)) ifc ();

  fetch_unit #(.PC_W(32), .RESET_PC(32'd0), .MEM_DEPTH(128)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_pc        (imem_pc),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (ifc),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_inst <= mem[imem_pc[5:0]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ifc.out_ready  = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | 32'(i);
    mem[6] = 32'h0801_1020;

    repeat (3) step();
    check("rst_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_pc",    ifc.out_pc,         32'd0);
    check("rst_inst",  ifc.out_inst,       32'd0);
    check("rst_imem",  imem_pc,            32'd0);
    check("rst_fault", 32'(fault),         32'd0);

    // Boot: BOOT cycle, issue, capture -> first valid on third edge
    rst_n = 1'b1;
    step();
    check("boot1_valid", 32'(ifc.out_valid), 32'd0);
    check("boot1_imem",  imem_pc,            32'd0);
    step();
    check("boot2_valid", 32'(ifc.out_valid), 32'd0);
    check("boot2_imem",  imem_pc,            32'd1);
    step();
    check("first_valid", 32'(ifc.out_valid), 32'd1);
    check("first_pc",    ifc.out_pc,         32'd0);
    check("first_inst",  ifc.out_inst,       32'h1000_0000);
    step();
    check("seq_pc1", ifc.out_pc, 32'd1);

    // Stall with decode not ready
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", 32'(ifc.out_valid), 32'd1);
      check("stall_pc",    ifc.out_pc,         32'd1);
      check("stall_imem",  imem_pc,            32'd3);
    end
    ifc.out_ready = 1'b1;
    step();
    check("drain_pc2", ifc.out_pc, 32'd2);
    step();
    check("drain_pc3",   ifc.out_pc,   32'd3);
    check("drain_inst3", ifc.out_inst, 32'h1000_0003);

    // External redirect to 40 while pc 4 is in flight
    redirect_valid = 1'b1; redirect_pc = 32'd40;
    step();
    redirect_valid = 1'b0;
    check("redir_flush_valid", 32'(ifc.out_valid), 32'd0);
    step();
    check("redir_gap_valid", 32'(ifc.out_valid), 32'd0);
    check("redir_imem",      imem_pc,            32'd41);
    step();
    check("redir_pc40",   ifc.out_pc,   32'd40);
    check("redir_inst40", ifc.out_inst, 32'h1000_0028);
    step();
    check("redir_pc41", ifc.out_pc, 32'd41);

    // Redirect to 10 in the same cycle the J at 6 is captured
    redirect_valid = 1'b1; redirect_pc = 32'd5;
    step();
    redirect_valid = 1'b0;
    check("rj_flush_valid", 32'(ifc.out_valid), 32'd0);
    step();
    check("rj_gap_valid", 32'(ifc.out_valid), 32'd0);
    check("rj_imem6",     imem_pc,            32'd6);
    step();
    check("rj_pc5", ifc.out_pc, 32'd5);
    redirect_valid = 1'b1; redirect_pc = 32'd10;
    step();
    redirect_valid = 1'b0;
    check("rj_kill_valid", 32'(ifc.out_valid), 32'd0);
    check("rj_imem10",     imem_pc,            32'd10);
    step();
    check("rj_gap2_valid", 32'(ifc.out_valid), 32'd0);
    check("rj_imem11",     imem_pc,            32'd11);
    step();
    check("rj_valid10", 32'(ifc.out_valid), 32'd1);
    check("rj_pc10",    ifc.out_pc,         32'd10);
    step();
    check("rj_pc11", ifc.out_pc, 32'd11);

    // J predecode: word 6 jumps to 0x11020
    redirect_valid = 1'b1; redirect_pc = 32'd5;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    check("j_pc5", ifc.out_pc, 32'd5);
    step();
    check("j_pc6",    ifc.out_pc,   32'd6);
    check("j_inst6",  ifc.out_inst, 32'h0801_1020);
    check("j_imem",   imem_pc,      32'h0001_1020);
    check("j_fault0", 32'(fault),   32'd0);
    step();
    check("j_gap_valid", 32'(ifc.out_valid), 32'd0);
`ifdef FETCH_BOUNDS_CHECK_EN
    check("bc_fault",  32'(fault), 32'd1);
    check("bc_imem",   imem_pc,    32'h0001_1020);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bc_halt_valid", 32'(ifc.out_valid), 32'd0);
      check("bc_halt_imem",  imem_pc,            32'h0001_1020);
      check("bc_halt_fault", 32'(fault),         32'd1);
    end
`else
    check("j_imem_next", imem_pc,    32'h0001_1021);
    check("j_nofault",   32'(fault), 32'd0);
    step();
    check("j_tgt_valid", 32'(ifc.out_valid), 32'd1);
    check("j_tgt_pc",    ifc.out_pc,         32'h0001_1020);
    check("j_tgt_inst",  ifc.out_inst,       32'h1000_0020);
    step();
    check("j_tgt_pc1", ifc.out_pc, 32'h0001_1021);
`endif

    // Asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(ifc.out_valid), 32'd0);
    check("arst_fault", 32'(fault),         32'd0);
    check("arst_imem",  imem_pc,            32'd0);
    check("arst_pc",    ifc.out_pc,         32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("reboot_gap_valid", 32'(ifc.out_valid), 32'd0);
    step();
    check("reboot_valid", 32'(ifc.out_valid), 32'd1);
    check("reboot_pc",    ifc.out_pc,         32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
